alu_pipe_responder: RTL and testbench

//  Pipelined, handshaked ALU responder. Accepts {ctrl,a,b} operation requests and returns {result,flags}.
//  Two register stages; valid/ready on both sides; full throughput of one op/clk.

---
 rtl/alu_pipe_responder.sv | 163 ++++++++++++++++
 tb/tb_alu_pipe_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_responder.sv
//------------------------------------------------------------------------------
// Module      : alu_pipe_responder
// Description : Two-stage valid/ready ALU responder returning {result, {N,Z,C,V}}.
//               Define ALU_STICKY_V_EN to add the sticky overflow flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_pipe_responder #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [2:0]           req_ctrl,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_result,
  output logic [3:0]           rsp_flags,
`ifdef ALU_STICKY_V_EN
  output logic                 sticky_v,
  input  logic                 sticky_clr,
`endif
  output logic [CNT_WIDTH-1:0] op_count
);

  localparam int c_shw = $clog2(WIDTH);

  localparam logic [2:0] c_op_add = 3'b000;
  localparam logic [2:0] c_op_sub = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_orr = 3'b011;
  localparam logic [2:0] c_op_eor = 3'b100;
  localparam logic [2:0] c_op_lsl = 3'b101;
  localparam logic [2:0] c_op_lsr = 3'b110;
  localparam logic [2:0] c_op_asr = 3'b111;

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 r_s1_valid;
  logic [2:0]           r_s1_ctrl;
  logic [WIDTH-1:0]     r_s1_a;
  logic [WIDTH-1:0]     r_s1_b;
  logic [WIDTH:0]       r_s1_sum;
  logic                 r_s2_valid;
  logic [WIDTH-1:0]     r_rsp_result;
  logic [3:0]           r_rsp_flags;
  logic [CNT_WIDTH-1:0] r_op_count;

  logic                 w_s1_en;
  logic                 w_s2_en;
  logic                 w_rsp_hs;
  logic                 w_req_sub;
  logic [WIDTH-1:0]     w_req_bop;
  logic [WIDTH:0]       w_req_sum;
  logic [c_shw-1:0]     w_sh;
  logic                 w_bop_msb;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c;
  logic                 w_v;

  assign w_s2_en  = ~r_s2_valid | rsp_ready;
  assign w_s1_en  = ~r_s1_valid | w_s2_en;
  assign w_rsp_hs = r_s2_valid & rsp_ready;

  // SUB is a + ~b + 1, so the carry out reads directly as "no borrow".
  assign w_req_sub = (req_ctrl == c_op_sub);
  assign w_req_bop = w_req_sub ? ~req_b : req_b;
  assign w_req_sum = {1'b0, req_a} + {1'b0, w_req_bop} + {{WIDTH{1'b0}}, w_req_sub};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_ctrl  <= 3'b000;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_sum   <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= req_valid;
      if (req_valid) begin
        r_s1_ctrl <= req_ctrl;
        r_s1_a    <= req_a;
        r_s1_b    <= req_b;
        r_s1_sum  <= w_req_sum;
      end
    end
  end

  assign w_sh      = r_s1_b[c_shw-1:0];
  assign w_bop_msb = r_s1_b[WIDTH-1] ^ (r_s1_ctrl == c_op_sub);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (r_s1_ctrl)
      c_op_add, c_op_sub: begin
        w_res = r_s1_sum[WIDTH-1:0];
        w_c   = r_s1_sum[WIDTH];
        w_v   = (r_s1_a[WIDTH-1] == w_bop_msb) & (r_s1_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      c_op_and: w_res = r_s1_a & r_s1_b;
      c_op_orr: w_res = r_s1_a | r_s1_b;
      c_op_eor: w_res = r_s1_a ^ r_s1_b;
      c_op_lsl: w_res = r_s1_a << w_sh;
      c_op_lsr: w_res = r_s1_a >> w_sh;
      c_op_asr: w_res = $unsigned($signed(r_s1_a) >>> w_sh);
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid   <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= 4'b0000;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rsp_result <= w_res;
        r_rsp_flags  <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op_count <= '0;
    end else if (w_rsp_hs) begin
      r_op_count <= r_op_count + c_cnt_one;
    end
  end

`ifdef ALU_STICKY_V_EN
  logic r_sticky_v;

  // Clear takes priority over a same-cycle overflow delivery.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky_v <= 1'b0;
    end else if (sticky_clr) begin
      r_sticky_v <= 1'b0;
    end else if (w_rsp_hs & r_rsp_flags[0]) begin
      r_sticky_v <= 1'b1;
    end
  end

  assign sticky_v = r_sticky_v;
`endif

  assign req_ready  = w_s1_en;
  assign rsp_valid  = r_s2_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign op_count   = r_op_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_pipe_responder
// Description : Directed self-checking bench for alu_pipe_responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_pipe_responder;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_ctrl;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [15:0] op_count;
`ifdef ALU_STICKY_V_EN
  logic        sticky_v;
  logic        sticky_clr;
`endif

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_cnt;

  alu_pipe_responder #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctrl   (req_ctrl),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
`ifdef ALU_STICKY_V_EN
    .sticky_v   (sticky_v),
    .sticky_clr (sticky_clr),
`endif
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_checks++;
    if (rsp_result !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_result got %h want 00000000", rsp_result); end
    n_checks++;
    if (rsp_flags !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_flags got %b want 0000", rsp_flags); end
    n_checks++;
    if (op_count !== 16'd0) begin n_fail++; $display("FAIL reset_op_count got %0d want 0", op_count); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
`ifdef ALU_STICKY_V_EN
    n_checks++;
    if (sticky_v !== 1'b0) begin n_fail++; $display("FAIL reset_sticky_v got %b want 0", sticky_v); end
`endif
  endtask

  // Single op with rsp_ready high; entered and left #1 after a rising edge.
  task automatic do_op(input logic [2:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input string nm,
                       input logic clr_at_dlv);
    req_ctrl  = ctrl;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL %s_req_ready got %b want 1", nm, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early_valid got %b want 0", nm, rsp_valid); end
    @(posedge clk); #1;
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid got %b want 1", nm, rsp_valid); end
    n_checks++;
    if (rsp_result !== er) begin n_fail++; $display("FAIL %s_result got %h want %h", nm, rsp_result, er); end
    n_checks++;
    if (rsp_flags !== ef) begin n_fail++; $display("FAIL %s_flags got %b want %b", nm, rsp_flags, ef); end
`ifdef ALU_STICKY_V_EN
    sticky_clr = clr_at_dlv;
`endif
    @(posedge clk); #1;
`ifdef ALU_STICKY_V_EN
    sticky_clr = 1'b0;
`endif
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL %s_drained got %b want 0", nm, rsp_valid); end
    n_checks++;
    if (op_count !== exp_cnt) begin n_fail++; $display("FAIL %s_op_count got %0d want %0d", nm, op_count, exp_cnt); end
  endtask

  task automatic test_ops();
    do_op(3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, "add_ovf", 1'b0);
    do_op(3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, "add_carry", 1'b0);
    do_op(3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110, "sub_eq", 1'b0);
    do_op(3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000, "sub_borrow", 1'b0);
    do_op(3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011, "sub_ovf", 1'b0);
    do_op(3'b010, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 4'b0100, "and", 1'b0);
    do_op(3'b011, 32'hF0F0F0F0, 32'h0000000F, 32'hF0F0F0FF, 4'b1000, "orr", 1'b0);
    do_op(3'b100, 32'hFFFF0000, 32'h0FF00FF0, 32'hF00F0FF0, 4'b1000, "eor", 1'b0);
    do_op(3'b101, 32'h00000001, 32'h0000001F, 32'h80000000, 4'b1000, "lsl", 1'b0);
    do_op(3'b110, 32'h80000000, 32'hFFFFFFE4, 32'h08000000, 4'b0000, "lsr", 1'b0);
    do_op(3'b111, 32'h80000000, 32'h00000004, 32'hF8000000, 4'b1000, "asr", 1'b0);
  endtask

  // 10 ADDs of (7FFFFFF0+i)+8 with the consumer stalled on cycles 3-6.
  task automatic test_back_to_back();
    int   sent;
    int   rcv;
    int   pend;
    int   stall_seen;
    logic acc;
    logic dlv;
    logic hold_v;
    logic [31:0] hold_r;
    logic [31:0] er;
    logic [3:0]  ef;
    sent = 0; rcv = 0; stall_seen = 0; hold_v = 1'b0; hold_r = '0;
    req_ctrl  = 3'b000;
    req_a     = 32'h7FFFFFF0;
    req_b     = 32'h00000008;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
      rsp_ready = !(cyc >= 3 && cyc <= 6);
      @(negedge clk);
      pend = sent - rcv;
      n_checks++;
      if (req_ready !== ((pend < 2) || rsp_ready)) begin
        n_fail++;
        $display("FAIL b2b_req_ready cyc %0d got %b want %b", cyc, req_ready, ((pend < 2) || rsp_ready));
      end
      if (req_ready === 1'b0) stall_seen++;
      if (hold_v && rsp_valid) begin
        n_checks++;
        if (rsp_result !== hold_r) begin n_fail++; $display("FAIL b2b_hold cyc %0d got %h want %h", cyc, rsp_result, hold_r); end
      end
      hold_v = rsp_valid && !rsp_ready;
      hold_r = rsp_result;
      dlv = rsp_valid && rsp_ready;
      if (dlv) begin
        er = 32'h7FFFFFF8 + rcv;
        ef = (rcv >= 8) ? 4'b1001 : 4'b0000;
        n_checks++;
        if (rsp_result !== er) begin n_fail++; $display("FAIL b2b_result #%0d got %h want %h", rcv, rsp_result, er); end
        n_checks++;
        if (rsp_flags !== ef) begin n_fail++; $display("FAIL b2b_flags #%0d got %b want %b", rcv, rsp_flags, ef); end
      end
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (dlv) rcv++;
      if (acc) begin
        sent++;
        if (sent < 10) req_a = 32'h7FFFFFF0 + sent;
        else req_valid = 1'b0;
      end
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    n_checks++;
    if (rcv !== 10) begin n_fail++; $display("FAIL b2b_count got %0d want 10", rcv); end
    n_checks++;
    if (stall_seen == 0) begin n_fail++; $display("FAIL b2b_full_stall got %0d want >0", stall_seen); end
    n_checks++;
    if (op_count !== 16'd10) begin n_fail++; $display("FAIL b2b_op_count got %0d want 10", op_count); end
    exp_cnt = 16'd10;
  endtask

  task automatic test_reset_inflight();
    rsp_ready = 1'b0;
    req_ctrl  = 3'b000;
    req_a     = 32'h00000001;
    req_b     = 32'h00000002;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_a = 32'h00000005;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rstfl_pre_valid got %b want 1", rsp_valid); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_valid got %b want 0", rsp_valid); end
    n_checks++;
    if (op_count !== 16'd0) begin n_fail++; $display("FAIL rstfl_op_count got %0d want 0", op_count); end
    @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstfl_stale cyc %0d got %b want 0", i, rsp_valid); end
    end
    n_checks++;
    if (op_count !== 16'd0) begin n_fail++; $display("FAIL rstfl_op_count_after got %0d want 0", op_count); end
    exp_cnt = 16'd0;
  endtask

`ifdef ALU_STICKY_V_EN
  task automatic test_sticky();
    do_op(3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, "stk_set", 1'b0);
    n_checks++;
    if (sticky_v !== 1'b1) begin n_fail++; $display("FAIL sticky_set got %b want 1", sticky_v); end
    do_op(3'b000, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, "stk_keep", 1'b0);
    n_checks++;
    if (sticky_v !== 1'b1) begin n_fail++; $display("FAIL sticky_persist got %b want 1", sticky_v); end
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    n_checks++;
    if (sticky_v !== 1'b0) begin n_fail++; $display("FAIL sticky_clr got %b want 0", sticky_v); end
    do_op(3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, "stk_race", 1'b1);
    n_checks++;
    if (sticky_v !== 1'b0) begin n_fail++; $display("FAIL sticky_clr_wins got %b want 0", sticky_v); end
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_cnt   = 16'd0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_ctrl  = 3'b000;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
`ifdef ALU_STICKY_V_EN
    sticky_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_back_to_back();
    test_ops();
    test_reset_inflight();
`ifdef ALU_STICKY_V_EN
    test_sticky();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
